// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM encoding
// and the default multiply timeout.
package alu_op_sequencer_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  localparam int unsigned MUL_TIMEOUT_DEFAULT = 64;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StStartMul,
    StWaitMul,
    StResp
  } seq_state_e;

  function automatic logic op_is_mul(logic [1:0] op);
    return op == ALU_MUL;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a one-bit last-served pointer.
module rr_arbiter2 (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_i,
  input  logic       en_i,
  output logic [1:0] grant_o
);

  // Requester 0 wins unless requester 1 is also asking and 0 was served last.
  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      if (req0_i && (!req1_i || last_i)) begin
        grant_o = 2'b01;
      end else if (req1_i) begin
        grant_o = 2'b10;
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer/arbiter in front of the 4-bit ALU. Accepts one operation at a
// time from two requesters, drives the ALU, and returns the result with a
// one-cycle valid strobe to the winner.
// Optional feature: define ALU_SEQ_TIMEOUT_EN to bound the multiply wait by
// MUL_TIMEOUT cycles and report Res_err on expiry.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned MUL_TIMEOUT = MUL_TIMEOUT_DEFAULT
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Req0,
  input  logic       Req1,
  input  logic [1:0] Op0,
  input  logic [1:0] Op1,
  input  logic [3:0] A0,
  input  logic [3:0] B0,
  input  logic [3:0] A1,
  input  logic [3:0] B1,
  output logic       Ack0,
  output logic       Ack1,
  output logic [7:0] Res,
  output logic       Res_cout,
  output logic       Res_err,
  output logic       Res_valid0,
  output logic       Res_valid1,
  output logic       Busy,
  output logic [3:0] Alu_A,
  output logic [3:0] Alu_B,
  output logic [1:0] Alu_Select,
  output logic       Alu_Init,
  input  logic       Alu_Done,
  input  logic [7:0] Alu_Result,
  input  logic       Alu_Cout
);

  seq_state_e state_q, state_d;

  logic [1:0] op_q;
  logic [3:0] a_q, b_q;
  logic       id_q;
  logic       last_q;
  logic [7:0] res_q;
  logic       res_cout_q;

  logic       arb_en;
  logic [1:0] grant;
  logic       accept;
  logic [1:0] sel_op;
  logic [3:0] sel_a, sel_b;
  logic       tmo_hit;

  // Never grant while reset is asserted so Ack stays low during reset.
  assign arb_en = (state_q == StIdle) && !Rst;
  assign accept = |grant;
  assign sel_op = grant[1] ? Op1 : Op0;
  assign sel_a  = grant[1] ? A1  : A0;
  assign sel_b  = grant[1] ? B1  : B0;

  rr_arbiter2 u_arb (
    .req0_i  (Req0),
    .req1_i  (Req1),
    .last_i  (last_q),
    .en_i    (arb_en),
    .grant_o (grant)
  );

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(MUL_TIMEOUT + 1);

  logic [CntW-1:0] tmo_q;
  logic            res_err_q;

  assign tmo_hit = (tmo_q == CntW'(MUL_TIMEOUT - 1));

  // Multiply wait counter: counts WAIT_MUL cycles, cleared everywhere else.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      tmo_q <= '0;
    end else if (state_q == StWaitMul) begin
      tmo_q <= tmo_q + CntW'(1);
    end else begin
      tmo_q <= '0;
    end
  end

  // Error flag is refreshed on every completion and held between strobes.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      res_err_q <= 1'b0;
    end else if (state_q == StExec || (state_q == StWaitMul && Alu_Done)) begin
      res_err_q <= 1'b0;
    end else if (state_q == StWaitMul && tmo_hit) begin
      res_err_q <= 1'b1;
    end
  end

  assign Res_err = res_err_q;
`else
  logic unused_cfg;

  assign tmo_hit    = 1'b0;
  assign Res_err    = 1'b0;
  assign unused_cfg = ^MUL_TIMEOUT;
`endif

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = op_is_mul(sel_op) ? StStartMul : StExec;
        end
      end
      StExec:     state_d = StResp;
      StStartMul: state_d = StWaitMul;
      StWaitMul: begin
        if (Alu_Done || tmo_hit) begin
          state_d = StResp;
        end
      end
      StResp:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Operand latches, result capture and last-served pointer.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      op_q       <= ALU_ADD;
      a_q        <= 4'h0;
      b_q        <= 4'h0;
      id_q       <= 1'b0;
      last_q     <= 1'b1;  // makes requester 0 the first winner on a tie
      res_q      <= 8'h00;
      res_cout_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= sel_op;
        a_q  <= sel_a;
        b_q  <= sel_b;
        id_q <= grant[1];
      end
      if (state_q == StExec) begin
        // Narrow ops only produce a nibble; AND has no carry.
        res_q      <= {4'h0, Alu_Result[3:0]};
        res_cout_q <= (op_q != ALU_AND) && Alu_Cout;
      end else if (state_q == StWaitMul && Alu_Done) begin
        res_q      <= Alu_Result;
        res_cout_q <= 1'b0;
      end else if (state_q == StWaitMul && tmo_hit) begin
        res_q      <= 8'h00;
        res_cout_q <= 1'b0;
      end
      if (state_q == StResp) begin
        last_q <= id_q;
      end
    end
  end

  // Outputs decoded from the current state and the grant.
  always_comb begin
    Ack0       = grant[0];
    Ack1       = grant[1];
    Busy       = (state_q != StIdle);
    Alu_Init   = (state_q != StStartMul);
    Res_valid0 = (state_q == StResp) && !id_q;
    Res_valid1 = (state_q == StResp) && id_q;
    Alu_A      = a_q;
    Alu_B      = b_q;
    Alu_Select = op_q;
    Res        = res_q;
    Res_cout   = res_cout_q;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequencer and arbiter in front of the 4-bit ALU top level (add/sub/multiply/AND, Select-coded, sequential multiplier with Init/Done). Two requesters submit operations through a request/acknowledge handshake. A round-robin arbiter picks one. The block drives the ALU operands and Select, generates the active-low Init pulse for multiplication, waits for the result and returns it to the winning requester with a one-cycle valid strobe.

## Interface
- `MUL_TIMEOUT`, default 64: cycles to wait for `Alu_Done` after the Init pulse (used only when the timeout is compiled in).
- `Clk` input 1: system clock, rising edge.
- `Rst` input 1: synchronous, active-high reset.
- `Req0`, `Req1` input 1 each: request from requester 0/1; held high until the matching Ack.
- `Op0`, `Op1` input 2 each: operation code; 00 add, 01 sub, 10 mul, 11 AND.
- `A0`, `B0`, `A1`, `B1` input 4 each: operands; stable while Req is high.
- `Ack0`, `Ack1` output 1 each: one-cycle acceptance strobe.
- `Res` output 8: result; add/sub/AND in bits [3:0] with [7:4]=0, mul uses all 8 bits.
- `Res_cout` output 1: ALU carry/borrow for add/sub; 0 for mul and AND.
- `Res_err` output 1: timeout flag, qualified by a valid strobe.
- `Res_valid0`, `Res_valid1` output 1 each: one-cycle result strobe to requester 0/1.
- `Busy` output 1: high in every state except IDLE.
- `Alu_A`, `Alu_B` output 4 each: to ALU `A`/`B`.
- `Alu_Select` output 2: to ALU `Select`.
- `Alu_Init` output 1: to ALU `Init`; idle high, active-low start pulse.
- `Alu_Done` input 1: from ALU `Done`.
- `Alu_Result` input 8: ALU result bus.
- `Alu_Cout` input 1: ALU `Cout`.

## Operation
- States: IDLE, EXEC, START_MUL, WAIT_MUL, RESP.
- **IDLE**
  - If any Req is high: arbitrate, pulse the matching Ack, latch Op/A/B and the requester id.
  - Then go to START_MUL if Op=10, else EXEC.
- **Arbitration**
  - Round robin on a 1-bit last-served pointer. Reset value favours requester 0.
  - If only one Req is high, that requester wins.
  - If both are high, the requester not served last wins.
- **EXEC**: drive the latched operands and Select for one cycle; capture `Alu_Result`/`Alu_Cout` at the end of the cycle, then go to RESP.
- **START_MUL**: `Alu_Init`=0 for exactly one cycle with operands and Select=10 driven, then go to WAIT_MUL.
- **WAIT_MUL**
  - `Alu_Init`=1. When `Alu_Done`=1 is sampled, capture `Alu_Result` and go to RESP.
  - `Alu_Done` in the START_MUL cycle is ignored.
- **RESP**
  - Drive the captured result and pulse the valid strobe of the latched requester for one cycle; update the last-served pointer; return to IDLE.
  - A new request can be acknowledged in the following IDLE cycle.
- **Latching**
  - Operands and Select stay latched until the next acceptance, so the ALU inputs are stable through the whole operation.
  - `Res`/`Res_cout`/`Res_err` hold their last values between strobes.
- Changes on Req/A/B/Op after Ack have no effect on the operation in flight.

## Timing
- **Reset values**
  - `Ack*`, `Res_valid*`, `Busy`, `Res`, `Res_cout`, `Res_err`, `Alu_A`, `Alu_B`, `Alu_Select` are 0.
  - `Alu_Init` is 1. State is IDLE; the pointer selects requester 0 first.
- **Add/sub/AND latency**: Ack in cycle n, EXEC in n+1, valid in n+2.
- **Multiply latency**: Ack in n, Init low in n+1, Done sampled in cycle m ≥ n+2, valid in m+1.
- **Throughput**: at most one accepted request every 3 cycles for add/sub/AND (IDLE, EXEC, RESP).
- **Reset during an operation**
  - Next cycle is IDLE with reset values; no valid strobe is issued for the aborted request.
  - The ALU multiplier is not reset by this block.

## Configuration
- `ALU_SEQ_TIMEOUT_EN` defined:
  - WAIT_MUL counts cycles. After `MUL_TIMEOUT` cycles without Done, go to RESP with `Res`=0, `Res_cout`=0, `Res_err`=1.
  - `Res_err`=0 on every normal completion.
- Not defined: no counter; WAIT_MUL waits indefinitely; `Res_err` is tied to 0.

## Structure
- Shared package:
  - opcode constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_MUL=2'b10, ALU_AND=2'b11;
  - state encoding;
  - default `MUL_TIMEOUT`.
- One sub-module, `rr_arbiter2`: inputs are the two requests, the last-served pointer and an enable; output is a one-hot grant.
- FSM, operand latches and result registers live in `alu_op_sequencer`.

## Test plan
- Req0 with Op=00, A=9, B=8 → Ack0 at n, `Res_valid0` at n+2 with `Res`=8'h01 and `Res_cout`=1.
- Req1 with Op=10, A=15, B=15, ALU model raising Done 10 cycles after Init → one-cycle Init low pulse; `Res_valid1` the cycle after Done with `Res`=8'd225.
- Req0 and Req1 high together, repeatedly, Op=11, A=4'hC, B=4'hA → grants alternate 0,1,0,1 starting with 0; each `Res`=8'h08.
- Rst asserted in WAIT_MUL → next cycle IDLE, `Alu_Init`=1, `Busy`=0; no valid strobe.
- `ALU_SEQ_TIMEOUT_EN` defined, Done never raised → valid 64 cycles after entering WAIT_MUL with `Res_err`=1 and `Res`=0.
- Op=01, A=3, B=5, with Req0 dropped and A changed right after Ack → `Res`=8'h0E (4-bit two's complement of -2), borrow reported on `Res_cout` per ALU convention; the change has no effect.
